// File: rtl/icode_count_arbiter.sv
// icode_count_arbiter: round-robin arbiter for two increment lanes over a per-icode counter array.
// Define ICNT_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module icode_count_arbiter #(
  parameter int ICODESIZE = 4,
  parameter int COUNTBITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [ICODESIZE-1:0] req0_icode,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ICODESIZE-1:0] req1_icode,
  output logic                 req1_ready,
  input  logic                 rd_valid,
  input  logic [ICODESIZE-1:0] rd_icode,
  output logic [COUNTBITS-1:0] rd_data,
  output logic                 rd_data_valid,
  input  logic                 clr_start,
  output logic                 busy
);
  localparam int DEPTH = 1 << ICODESIZE;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t               r_state;
  logic [ICODESIZE-1:0] r_clr_addr;
  logic [ICODESIZE-1:0] r_upd_icode;
  logic                 r_upd_valid;
  logic                 r_ptr;
  logic [COUNTBITS-1:0] r_mem [DEPTH];
  logic                 w_open;
  logic                 w_acc;
  logic [ICODESIZE-1:0] w_acc_icode;
  logic [COUNTBITS-1:0] w_cur;
  logic [COUNTBITS-1:0] w_inc;
  assign w_open      = r_state == RUN && !clr_start;
  assign req0_ready  = w_open && req0_valid && (!req1_valid || !r_ptr);
  assign req1_ready  = w_open && req1_valid && (!req0_valid || r_ptr);
  assign w_acc       = req0_ready || req1_ready;
  assign w_acc_icode = req1_ready ? req1_icode : req0_icode;
  assign busy        = r_state == CLEAR;
  // The array is read after the previous write-back, so back-to-back hits on one icode stay coherent.
  assign w_cur = r_mem[r_upd_icode];
`ifdef ICNT_SATURATE_EN
  assign w_inc = &w_cur ? w_cur : w_cur + 1'b1;
`else
  assign w_inc = w_cur + 1'b1;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= CLEAR;
      r_clr_addr    <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_icode   <= '0;
      r_ptr         <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= r_state == RUN && rd_valid;
      if (r_state == RUN && rd_valid)
        rd_data <= (r_upd_valid && r_upd_icode == rd_icode) ? w_inc : r_mem[rd_icode];
      if (r_state == CLEAR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
        if (&r_clr_addr) r_state <= RUN;
      end else if (clr_start) begin
        r_state    <= CLEAR;
        r_clr_addr <= '0;
      end
      r_upd_valid <= w_acc;
      if (w_acc) r_upd_icode <= w_acc_icode;
      if (w_acc && req0_valid && req1_valid) r_ptr <= !r_ptr;
    end
  end
  // A clear request drops the pending write-back.
  always_ff @(posedge clock) begin
    if (r_state == CLEAR) r_mem[r_clr_addr] <= '0;
    else if (r_upd_valid && !clr_start) r_mem[r_upd_icode] <= w_inc;
  end
endmodule

// File: tb/tb_icode_count_arbiter.sv
// tb_icode_count_arbiter: directed stimulus with a read-data scoreboard for icode_count_arbiter.
module tb_icode_count_arbiter;
  logic       clock = 0, reset = 0;
  logic       req0_valid = 0, req1_valid = 0, rd_valid = 0, clr_start = 0;
  logic [3:0] req0_icode = 0, req1_icode = 0, rd_icode = 0;
  logic       req0_ready, req1_ready, rd_data_valid, busy;
  logic [3:0] rd_data;
  int         total = 0, bad = 0;
  int         model [16];
  bit         ptr = 0;
  logic [3:0] exp_q [$];

  always #5 clock = ~clock;

  icode_count_arbiter #(.ICODESIZE(4), .COUNTBITS(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_icode(req0_icode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_icode(req1_icode), .req1_ready(req1_ready),
    .rd_valid(rd_valid), .rd_icode(rd_icode), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .clr_start(clr_start), .busy(busy)
  );

  function automatic int inc(int v);
`ifdef ICNT_SATURATE_EN
    return v == 15 ? 15 : v + 1;
`else
    return (v + 1) % 16;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (reset && rd_data_valid) begin
      if (exp_q.size() == 0) check("unexpected_rd_data_valid", 1, 0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic req(bit v0, int i0, bit v1, int i1);
    bit e0, e1;
    req0_valid = v0; req0_icode = 4'(i0);
    req1_valid = v1; req1_icode = 4'(i1);
    e0 = v0 && (!v1 || !ptr);
    e1 = v1 && (!v0 || ptr);
    @(negedge clock);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    if (e0) model[i0] = inc(model[i0]);
    if (e1) model[i1] = inc(model[i1]);
    if (v0 && v1) ptr = !ptr;
    tick;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic rd(int ic);
    rd_valid = 1; rd_icode = 4'(ic);
    exp_q.push_back(4'(model[ic]));
    tick;
    rd_valid = 0;
  endtask

  task automatic wait_clear(bit poke);
    int n = 0;
    req0_valid = 1; req0_icode = 4'd5; req1_valid = 1; req1_icode = 4'd6;
    rd_valid = 1; rd_icode = 4'd5;
    while (n < 100) begin
      @(negedge clock);
      if (!busy) break;
      n++;
      check("ready_in_clear", {req0_ready, req1_ready}, 0);
      clr_start = poke && n == 5;
    end
    clr_start = 0; req0_valid = 0; req1_valid = 0; rd_valid = 0;
    check("clear_cycles", n, 16);
    foreach (model[i]) model[i] = 0;
  endtask

  initial begin
    foreach (model[i]) model[i] = 0;
    req0_valid = 1; req1_valid = 1;
    #12;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_data_valid", rd_data_valid, 0);
    req0_valid = 0; req1_valid = 0;
    tick;
    reset = 1;
    wait_clear(0);
    for (int i = 0; i < 16; i++) rd(i);
    repeat (5) req(1, 3, 0, 0);
    rd(3);
    rd_valid = 1; rd_icode = 4'd3; exp_q.push_back(4'(model[3]));
    req(1, 3, 0, 0);
    rd_valid = 0;
    rd(3);
    repeat (6) req(1, 2, 1, 7);
    rd(2);
    rd(7);
    repeat (8) req(1, 9, 1, 9);
    repeat (9) req(0, 0, 1, 9);
    req(1, 1, 1, 2);
    rd(9);
    rd(1);
    rd(2);
    req(1, 4, 0, 0);
    clr_start = 1; req0_valid = 1; req0_icode = 4'd4;
    @(negedge clock);
    check("clr_blocks_req0", req0_ready, 0);
    check("clr_busy_still_0", busy, 0);
    tick;
    clr_start = 0; req0_valid = 0;
    wait_clear(1);
    rd(4);
    rd(3);
    repeat (3) req(1, 1, 0, 0);
    rd(1);
    @(negedge clock);
    req0_valid = 1; req0_icode = 4'd1;
    tick;
    reset = 0;
    #1;
    check("mid_rst_req0_ready", req0_ready, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_rd_data_valid", rd_data_valid, 0);
    req0_valid = 0;
    tick;
    tick;
    reset = 1; ptr = 0;
    wait_clear(0);
    rd(1);
    repeat (4) tick;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
